pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the load and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers and the PC register.
- Freezes the whole pipeline on instruction- or data-memory waits, tracking split completion when both are outstanding.
- Inserts a load-use bubble, squashes younger stages on a taken branch or jump resolved in MEM, and keeps saturating stall counters.

Parameters:
- CNT_W, 16, width of each stall performance counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- imem_read  in  1  IF stage has a fetch outstanding this cycle.
- imem_resp  in  1  instruction memory returns data this cycle.
- dmem_req  in  1  MEM stage holds a load or store.
- dmem_resp  in  1  data memory completes the access this cycle.
- ld_use  in  1  ID instruction sources rd of a load in EX.
- br_taken  in  1  MEM-stage cmp/jump resolves taken (redirect).
- imem_read_en  out  1  gated fetch request to I-memory.
- dmem_en  out  1  gated access request to D-memory.
- ifetch_hold  out  1  IF/ID takes the latched instruction instead of live memory data.
- load_pc  out  1  PC register load.
- pc_sel  out  1  1 = take branch target, 0 = PC+4.
- load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  pipe register loads.
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  synchronous clear to NOP, applied together with load.
- istall_cnt, dstall_cnt, bubble_cnt  out  CNT_W each  saturating counters.

Behaviour:
- Reset:
  - state=RUN, all counters 0.
  - While reset is high: all load_* = 0, all flush_* = 1, imem_read_en = 0, dmem_en = 0, ifetch_hold = 0, pc_sel = 0.
  - Reset mid-wait abandons the pending access and returns to RUN.
- Outputs are combinational from state and inputs. State and counters are registered. Zero-cycle latency from input to controls.
- FSM states: RUN, I_DONE (instruction received and latched externally, D still pending), D_DONE (D completed, I still pending).
- Sides:
  - i_ok = imem_resp | !imem_read | (state==I_DONE).
  - d_ok = dmem_resp | !dmem_req | (state==D_DONE).
  - advance = i_ok & d_ok.
- RUN transitions:
  - advance → stay RUN.
  - imem_resp & !d_ok → I_DONE.
  - dmem_resp & !i_ok → D_DONE.
  - Otherwise stay RUN.
- I_DONE: imem_read_en = 0; ifetch_hold = 1. dmem_resp → RUN with advance.
- D_DONE: dmem_en = 0. imem_resp → RUN with advance.
- In RUN: imem_read_en = imem_read and dmem_en = dmem_req.
- !advance: all load_* = 0, all flush_* = 0. Nothing moves, including WB.
- advance, priority branch > load-use:
  - br_taken: all loads = 1, pc_sel = 1, flush_if_id = flush_id_ex = flush_ex_mem = 1. ld_use is ignored.
  - else ld_use: load_pc = 0, load_if_id = 0, load_id_ex = 1 with flush_id_ex = 1 (bubble), load_ex_mem = 1, load_mem_wb = 1.
  - else: all loads = 1, no flush, pc_sel = 0.
- Counters, each cycle, saturating at all-ones (no wrap):
  - istall_cnt += 1 when !advance & !i_ok.
  - dstall_cnt += 1 when !advance & !d_ok.
  - Both increment in the same cycle if both sides wait.
  - bubble_cnt += 1 on each load-use bubble cycle.
- Simultaneous imem_resp & dmem_resp in RUN → advance, stay RUN.

Test Plan:
- No hazards: imem_read=1, imem_resp=1 every cycle, dmem_req=0 for 10 cycles → all loads = 1 every cycle, flushes 0, counters stay 0.
- I-miss: imem_resp low for 3 cycles, then high → loads = 0 for 3 cycles, advance on the 4th, istall_cnt=3, dstall_cnt=0.
- Split completion: dmem_req=1; imem_resp arrives cycle 1; dmem_resp arrives cycle 4 → state I_DONE cycles 2-4, imem_read_en = 0 and ifetch_hold = 1 there, single advance at cycle 4, then RUN; dstall_cnt=3, istall_cnt=1.
- Load-use with branch: ld_use=1 alone → load_pc = load_if_id = 0, flush_id_ex = 1, bubble_cnt=1. ld_use=1 with br_taken=1 → pc_sel=1, three flushes, no bubble counted.
- Branch during D-wait: br_taken=1, dmem_resp low 2 cycles → no flush for 2 cycles, flushes plus pc_sel=1 only on the advance cycle.
- Reset mid-D_DONE, then saturation: reset asserted in D_DONE → state RUN and counters 0 next cycle. Hold the I-miss 2^CNT_W+5 cycles → istall_cnt sticks at all-ones.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_if
//   Bundle between the 5-stage pipeline datapath and its stall/flush
//   sequencer.
//   master : datapath side; drives hazard and memory status and receives the
//            pipe-register controls.
//   slave  : sequencer side.
//   Status  : imem_read, imem_resp, dmem_req, dmem_resp, ld_use, br_taken
//   Controls: imem_read_en, dmem_en, ifetch_hold, load_pc, pc_sel,
//             load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
//             flush_if_id, flush_id_ex, flush_ex_mem
// ---------------------------------------------------------------------------
interface pipe_stall_ctrl_if;
    // hazard / memory status
    logic imem_read;
    logic imem_resp;
    logic dmem_req;
    logic dmem_resp;
    logic ld_use;
    logic br_taken;

    // pipeline controls
    logic imem_read_en;
    logic dmem_en;
    logic ifetch_hold;
    logic load_pc;
    logic pc_sel;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;

    modport master (
        output imem_read, imem_resp, dmem_req, dmem_resp, ld_use, br_taken,
        input  imem_read_en, dmem_en, ifetch_hold, load_pc, pc_sel,
               load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem
    );

    modport slave (
        input  imem_read, imem_resp, dmem_req, dmem_resp, ld_use, br_taken,
        output imem_read_en, dmem_en, ifetch_hold, load_pc, pc_sel,
               load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//   Stall/flush sequencer for a 5-stage RISC-V pipeline. Freezes the whole
//   pipe while instruction or data memory is waiting (remembering which side
//   already finished when both were outstanding), inserts a load-use bubble
//   into ID/EX, and squashes younger stages on a taken branch resolved in MEM.
//   Controls are combinational from state and inputs; state and the
//   saturating stall counters are registered.
//
//   clk        : clock, all state updates on posedge
//   reset      : synchronous, active-high
//   bus        : pipe_stall_ctrl_if.slave (status in, controls out)
//   istall_cnt : cycles frozen waiting on instruction memory
//   dstall_cnt : cycles frozen waiting on data memory
//   bubble_cnt : load-use bubbles inserted
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    pipe_stall_ctrl_if.slave bus,
    output logic [CNT_W-1:0] istall_cnt,
    output logic [CNT_W-1:0] dstall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    // I_DONE: fetch data already latched externally, data side still pending.
    // D_DONE: data access completed, fetch still pending.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        I_DONE = 2'd1,
        D_DONE = 2'd2
    } state_t;

    state_t state;
    logic   i_ok;
    logic   d_ok;
    logic   advance;
    logic   bubble;

    // A side is satisfied when it responds now, has nothing outstanding, or
    // already completed in an earlier cycle of this wait.
    assign i_ok    = bus.imem_resp | ~bus.imem_read | (state == I_DONE);
    assign d_ok    = bus.dmem_resp | ~bus.dmem_req  | (state == D_DONE);
    assign advance = i_ok & d_ok;
    assign bubble  = advance & ~bus.br_taken & bus.ld_use;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        bus.imem_read_en = 1'b0;
        bus.dmem_en      = 1'b0;
        bus.ifetch_hold  = 1'b0;
        bus.load_pc      = 1'b0;
        bus.pc_sel       = 1'b0;
        bus.load_if_id   = 1'b0;
        bus.load_id_ex   = 1'b0;
        bus.load_ex_mem  = 1'b0;
        bus.load_mem_wb  = 1'b0;
        bus.flush_if_id  = 1'b0;
        bus.flush_id_ex  = 1'b0;
        bus.flush_ex_mem = 1'b0;

        if (reset) begin
            // Hold every pipe register at NOP while in reset.
            bus.flush_if_id  = 1'b1;
            bus.flush_id_ex  = 1'b1;
            bus.flush_ex_mem = 1'b1;
        end else begin
            // A side that already completed must not re-issue its request.
            bus.imem_read_en = bus.imem_read & (state != I_DONE);
            bus.dmem_en      = bus.dmem_req  & (state != D_DONE);
            bus.ifetch_hold  = (state == I_DONE);

            if (advance) begin
                if (bus.br_taken) begin
                    // Redirect wins over load-use: the dependent instruction
                    // is squashed anyway.
                    bus.load_pc      = 1'b1;
                    bus.pc_sel       = 1'b1;
                    bus.load_if_id   = 1'b1;
                    bus.load_id_ex   = 1'b1;
                    bus.load_ex_mem  = 1'b1;
                    bus.load_mem_wb  = 1'b1;
                    bus.flush_if_id  = 1'b1;
                    bus.flush_id_ex  = 1'b1;
                    bus.flush_ex_mem = 1'b1;
                end else if (bus.ld_use) begin
                    // Hold PC and IF/ID, drop a NOP into ID/EX.
                    bus.load_id_ex   = 1'b1;
                    bus.flush_id_ex  = 1'b1;
                    bus.load_ex_mem  = 1'b1;
                    bus.load_mem_wb  = 1'b1;
                end else begin
                    bus.load_pc      = 1'b1;
                    bus.load_if_id   = 1'b1;
                    bus.load_id_ex   = 1'b1;
                    bus.load_ex_mem  = 1'b1;
                    bus.load_mem_wb  = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Abandons any pending split wait.
            state      <= RUN;
            istall_cnt <= '0;
            dstall_cnt <= '0;
            bubble_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (!advance) begin
                        if (bus.imem_resp && !d_ok)
                            state <= I_DONE;
                        else if (bus.dmem_resp && !i_ok)
                            state <= D_DONE;
                    end
                end
                I_DONE:  if (advance) state <= RUN;
                D_DONE:  if (advance) state <= RUN;
                default: state <= RUN;
            endcase

            if (!advance && !i_ok && istall_cnt != '1)
                istall_cnt <= istall_cnt + 1'b1;
            if (!advance && !d_ok && dstall_cnt != '1)
                dstall_cnt <= dstall_cnt + 1'b1;
            if (bubble && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
//   Directed bench for pipe_stall_ctrl. Inputs change 1 ns after the rising
//   edge; controls are compared 1 ns later and counters right after an edge.
//   Control vectors are packed in the order
//   {imem_read_en, dmem_en, ifetch_hold, load_pc, pc_sel,
//    load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
//    flush_if_id, flush_id_ex, flush_ex_mem}.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

    localparam int CNT_W = 16;

    // Expected control patterns (field order as above).
    localparam logic [11:0] C_RESET   = 12'b0_0_0_0_0_0000_111;
    localparam logic [11:0] C_NORMAL  = 12'b1_0_0_1_0_1111_000;
    localparam logic [11:0] C_ISTALL  = 12'b1_0_0_0_0_0000_000;
    localparam logic [11:0] C_BOTHREQ = 12'b1_1_0_0_0_0000_000;
    localparam logic [11:0] C_IDONE   = 12'b0_1_1_0_0_0000_000;
    localparam logic [11:0] C_IDONE_GO= 12'b0_1_1_1_0_1111_000;
    localparam logic [11:0] C_BUBBLE  = 12'b1_0_0_0_0_0111_010;
    localparam logic [11:0] C_BRANCH  = 12'b1_0_0_1_1_1111_111;
    localparam logic [11:0] C_DWAIT   = 12'b0_1_0_0_0_0000_000;
    localparam logic [11:0] C_DBRANCH = 12'b0_1_0_1_1_1111_111;

    logic clk;
    logic reset;
    logic [CNT_W-1:0] istall_cnt;
    logic [CNT_W-1:0] dstall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    int n_checks;
    int n_pass;

    pipe_stall_ctrl_if bus ();

    pipe_stall_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .istall_cnt (istall_cnt),
        .dstall_cnt (dstall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [11:0] ctl();
        return {bus.imem_read_en, bus.dmem_en, bus.ifetch_hold, bus.load_pc, bus.pc_sel,
                bus.load_if_id, bus.load_id_ex, bus.load_ex_mem, bus.load_mem_wb,
                bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic ir, input logic irsp, input logic dr,
                         input logic drsp, input logic lu, input logic br);
        bus.imem_read = ir;
        bus.imem_resp = irsp;
        bus.dmem_req  = dr;
        bus.dmem_resp = drsp;
        bus.ld_use    = lu;
        bus.br_taken  = br;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply(1, 1, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
    endtask

    task automatic check_cnts(input string tag, input int is, input int ds, input int bb);
        check({tag, " istall"}, 32'(istall_cnt), 32'(is));
        check({tag, " dstall"}, 32'(dstall_cnt), 32'(ds));
        check({tag, " bubble"}, 32'(bubble_cnt), 32'(bb));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        apply(1, 1, 1, 0, 1, 1);

        // Reset: controls forced regardless of inputs, counters cleared.
        tick();
        check("reset ctl", 32'(ctl()), 32'(C_RESET));
        tick();
        check_cnts("reset", 0, 0, 0);
        reset = 1'b0;

        // No hazards for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            apply(1, 1, 0, 0, 0, 0);
            check($sformatf("nohaz ctl c%0d", i), 32'(ctl()), 32'(C_NORMAL));
            tick();
        end
        check_cnts("nohaz", 0, 0, 0);

        // I-miss: three frozen cycles, advance on the fourth.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 0, 0, 0, 0);
            check($sformatf("imiss ctl c%0d", i), 32'(ctl()), 32'(C_ISTALL));
            tick();
        end
        apply(1, 1, 0, 0, 0, 0);
        check("imiss advance", 32'(ctl()), 32'(C_NORMAL));
        tick();
        check_cnts("imiss", 3, 0, 0);

        // Split completion: one I-wait cycle, I returns while D pending,
        // I_DONE for cycles 2-4, single advance when D returns.
        do_reset();
        apply(1, 0, 0, 0, 0, 0);
        check("split c0", 32'(ctl()), 32'(C_ISTALL));
        tick();
        apply(1, 1, 1, 0, 0, 0);
        check("split c1", 32'(ctl()), 32'(C_BOTHREQ));
        tick();
        for (int i = 2; i < 4; i++) begin
            apply(1, 0, 1, 0, 0, 0);
            check($sformatf("split idone c%0d", i), 32'(ctl()), 32'(C_IDONE));
            tick();
        end
        apply(1, 0, 1, 1, 0, 0);
        check("split c4 advance", 32'(ctl()), 32'(C_IDONE_GO));
        tick();
        check_cnts("split", 1, 3, 0);
        apply(1, 1, 0, 0, 0, 0);
        check("split back in RUN", 32'(ctl()), 32'(C_NORMAL));
        tick();

        // Load-use alone, then with a taken branch, then during a stall.
        do_reset();
        apply(1, 1, 0, 0, 1, 0);
        check("lduse ctl", 32'(ctl()), 32'(C_BUBBLE));
        tick();
        check_cnts("lduse", 0, 0, 1);
        apply(1, 1, 0, 0, 1, 1);
        check("lduse+br ctl", 32'(ctl()), 32'(C_BRANCH));
        tick();
        check("lduse+br bubble", 32'(bubble_cnt), 32'd1);
        apply(1, 0, 0, 0, 1, 0);
        check("lduse stalled ctl", 32'(ctl()), 32'(C_ISTALL));
        tick();
        check_cnts("lduse stalled", 1, 0, 1);

        // Branch waiting on D-memory: no flush until the advance cycle.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 1, 0, 0, 1);
            check($sformatf("brdwait c%0d", i), 32'(ctl()), 32'(C_DWAIT));
            tick();
        end
        apply(0, 0, 1, 1, 0, 1);
        check("brdwait advance", 32'(ctl()), 32'(C_DBRANCH));
        tick();
        check_cnts("brdwait", 0, 2, 0);

        // Simultaneous responses in RUN advance without a split state.
        apply(1, 1, 1, 1, 0, 0);
        check("both resp", 32'(ctl()), 32'(12'b1_1_0_1_0_1111_000));
        tick();
        check_cnts("both resp", 0, 2, 0);

        // Enter D_DONE, then reset out of it.
        do_reset();
        apply(1, 0, 1, 1, 0, 0);
        check("ddone entry", 32'(ctl()), 32'(C_BOTHREQ));
        tick();
        apply(1, 0, 1, 0, 0, 0);
        check("ddone ctl", 32'(ctl()), 32'(C_ISTALL));
        tick();
        check_cnts("ddone", 2, 0, 0);
        reset = 1'b1;
        #1;
        check("reset in ddone ctl", 32'(ctl()), 32'(C_RESET));
        tick();
        reset = 1'b0;
        check_cnts("after ddone reset", 0, 0, 0);
        apply(1, 0, 1, 0, 0, 0);
        check("RUN after reset", 32'(ctl()), 32'(C_BOTHREQ));
        tick();
        check_cnts("post reset wait", 1, 1, 0);

        // Saturation: keep the I-miss past the counter range.
        apply(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < (1 << CNT_W) + 5; i++)
            tick();
        check("istall saturated", 32'(istall_cnt), 32'({CNT_W{1'b1}}));
        check("dstall unchanged", 32'(dstall_cnt), 32'd1);
        tick();
        check("istall stays", 32'(istall_cnt), 32'({CNT_W{1'b1}}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
